// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
// Owns the single write port of the register file. Two writeback sources
// (ALU and load unit) compete for it through valid/ready handshakes with
// round-robin arbitration. An accepted request is registered and presented
// to the register file one cycle later. A pending-write scoreboard flags
// read-after-write hazards on the issue stage's two read addresses.
module regfile_wb_arbiter #(
    parameter int DATA_W   = 19,
    parameter int ADDR_W   = 4,
    parameter int NUM_REGS = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                alu_valid,
    output logic                alu_ready,
    input  logic [ADDR_W-1:0]   alu_rd,
    input  logic [DATA_W-1:0]   alu_data,
    input  logic                mem_valid,
    output logic                mem_ready,
    input  logic [ADDR_W-1:0]   mem_rd,
    input  logic [DATA_W-1:0]   mem_data,
    input  logic                issue_valid,
    input  logic [ADDR_W-1:0]   issue_rd,
    input  logic [ADDR_W-1:0]   rs1,
    input  logic [ADDR_W-1:0]   rs2,
    output logic                rs_hazard,
    output logic                RegWrite,
    output logic [ADDR_W-1:0]   WriteReg,
    output logic [DATA_W-1:0]   WriteData,
    output logic [NUM_REGS-1:0] busy_mask
);

    // Identity of the most recent winner; the other side wins the next tie.
    typedef enum logic {
        GRANT_ALU = 1'b0,
        GRANT_MEM = 1'b1
    } grant_e;

    grant_e              lastGrant_r;
    grant_e              lastGrantNext_s;

    logic                aluReady_s;
    logic                memReady_s;
    logic                xfer_s;
    logic [ADDR_W-1:0]   xferRd_s;
    logic [DATA_W-1:0]   xferData_s;

    logic                regWrite_r;
    logic [ADDR_W-1:0]   writeReg_r;
    logic [DATA_W-1:0]   writeData_r;

    logic [NUM_REGS-1:0] busy_r;
    logic [NUM_REGS-1:0] busyNext_s;

    // Round-robin grant: a lone requester always wins, a tie goes to the
    // side that did not win last. Ready depends only on valids and history.
    always_comb begin
        aluReady_s = 1'b0;
        memReady_s = 1'b0;
        case ({alu_valid, mem_valid})
            2'b10: begin
                aluReady_s = 1'b1;
            end
            2'b01: begin
                memReady_s = 1'b1;
            end
            2'b11: begin
                if (lastGrant_r == GRANT_MEM) begin
                    aluReady_s = 1'b1;
                end else begin
                    memReady_s = 1'b1;
                end
            end
            default: begin
                aluReady_s = 1'b0;
                memReady_s = 1'b0;
            end
        endcase
    end

    // Select the transferring request and the next grant history.
    always_comb begin
        xfer_s          = aluReady_s | memReady_s;
        xferRd_s        = {ADDR_W{1'b0}};
        xferData_s      = {DATA_W{1'b0}};
        lastGrantNext_s = lastGrant_r;
        if (aluReady_s) begin
            xferRd_s        = alu_rd;
            xferData_s      = alu_data;
            lastGrantNext_s = GRANT_ALU;
        end else if (memReady_s) begin
            xferRd_s        = mem_rd;
            xferData_s      = mem_data;
            lastGrantNext_s = GRANT_MEM;
        end else begin
            lastGrantNext_s = lastGrant_r;
        end
    end

    // Scoreboard update: a transfer retires its destination, an issue marks
    // its destination pending. The issue is applied last so it wins a
    // same-register collision (it belongs to the younger instruction).
    always_comb begin
        busyNext_s = busy_r;
        if (xfer_s) begin
            busyNext_s[xferRd_s] = 1'b0;
        end else begin
            busyNext_s = busy_r;
        end
        if (issue_valid) begin
            busyNext_s[issue_rd] = 1'b1;
        end else begin
            busyNext_s = busyNext_s;
        end
    end

    // Grant history; reset to MEM so the ALU wins the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lastGrant_r <= GRANT_MEM;
        end else begin
            lastGrant_r <= lastGrantNext_s;
        end
    end

    // Register-file write port: one cycle after a transfer. Address and data
    // hold when idle; reset drops any accepted-but-uncommitted write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regWrite_r  <= 1'b0;
            writeReg_r  <= {ADDR_W{1'b0}};
            writeData_r <= {DATA_W{1'b0}};
        end else begin
            regWrite_r <= xfer_s;
            if (xfer_s) begin
                writeReg_r  <= xferRd_s;
                writeData_r <= xferData_s;
            end
        end
    end

    // Pending-write scoreboard state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_r <= {NUM_REGS{1'b0}};
        end else begin
            busy_r <= busyNext_s;
        end
    end

    assign alu_ready = aluReady_s;
    assign mem_ready = memReady_s;
    assign RegWrite  = regWrite_r;
    assign WriteReg  = writeReg_r;
    assign WriteData = writeData_r;
    assign busy_mask = busy_r;

    // During the commit cycle the register file still returns the old value,
    // so the register being written is treated as a hazard too.
    assign rs_hazard = busy_r[rs1] | busy_r[rs2] |
                       (regWrite_r && ((writeReg_r == rs1) || (writeReg_r == rs2)));

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Owns the single write port of the 16 x 19-bit register file.
- Arbitrates writeback requests from the ALU and the memory/load unit using round-robin with valid/ready handshakes.
- Drives the register file's RegWrite/WriteReg/WriteData inputs from registered outputs.
- Keeps a pending-write scoreboard and flags read-after-write hazards on the two read-register addresses to the issue stage.

Parameters:
DATA_W, 19, register/data width
ADDR_W, 4, register address width
NUM_REGS, 16, register count (2**ADDR_W)

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
alu_valid  input  1  ALU writeback request
alu_ready  output  1  ALU request accepted this cycle
alu_rd  input  ADDR_W  ALU destination register
alu_data  input  DATA_W  ALU result
mem_valid  input  1  load-unit writeback request
mem_ready  output  1  load request accepted this cycle
mem_rd  input  ADDR_W  load destination register
mem_data  input  DATA_W  load data
issue_valid  input  1  an instruction writing issue_rd is issued this cycle
issue_rd  input  ADDR_W  destination of the issued instruction
rs1  input  ADDR_W  ReadReg1 address being read by the issue stage
rs2  input  ADDR_W  ReadReg2 address being read by the issue stage
rs_hazard  output  1  rs1 or rs2 has a write pending; issue must stall
RegWrite  output  1  register-file write enable
WriteReg  output  ADDR_W  register-file write address
WriteData  output  DATA_W  register-file write data
busy_mask  output  NUM_REGS  scoreboard; bit n set = write to Rn pending

Behaviour:
- Reset (async assert, rst_n low): RegWrite=0, WriteReg=0, WriteData=0, busy_mask=0, last_grant=MEM so the ALU wins the first tie.
  - A request in flight at reset is dropped, with no write.
  - Release is synchronous to clk.
- Handshake:
  - alu_ready and mem_ready are combinational from the valids and last_grant.
  - A transfer occurs when valid&&ready. At most one ready is high per cycle.
  - A requester must hold valid, rd and data stable until accepted. ready never depends on data.
- Arbitration:
  - Only one valid: grant it.
  - Both valid: grant the requester that is not last_grant.
  - last_grant updates only on a transfer.
  - A waiting requester is granted within 1 competing transfer; there is no idle cycle between back-to-back grants.
- Write timing: one-cycle latency.
  - On a transfer in cycle N, the next edge registers RegWrite=1, WriteReg=rd, WriteData=data for cycle N+1. The register file commits on the following edge.
  - With no transfer in cycle N, RegWrite=0 in N+1; WriteReg/WriteData hold their last values.
  - Sustained throughput is one write per cycle.
- Scoreboard:
  - issue_valid sets busy[issue_rd].
  - A transfer clears busy[rd] at the same edge.
  - Same edge, same register, set and clear: set wins, because the issue is the younger instruction.
  - Setting an already-busy bit is legal. There is no per-register counting: the first write clears it.
- Hazard (combinational): rs_hazard = busy[rs1] | busy[rs2] | (RegWrite && (WriteReg==rs1 || WriteReg==rs2)).
  - The second term covers the commit cycle, when the register file still returns old data.
- R0 is an ordinary register: writable and tracked.
- rd values are not checked for range; the full ADDR_W space is valid.

Test Plan:
- Reset mid-stream: alu_valid=1, alu_rd=3, alu_data=19'h12345, rst_n pulsed low between accept and commit -> RegWrite=0 immediately, busy_mask=0, no write to R3.
- Single ALU write: alu_valid=1, alu_rd=5, alu_data=19'h7FFFF in cycle 0 -> alu_ready=1 in cycle 0; cycle 1 RegWrite=1, WriteReg=5, WriteData=19'h7FFFF; cycle 2 RegWrite=0.
- Contention: both valid from cycle 0 with alu_rd=1/0x00011 and mem_rd=2/0x00022, each dropping valid after acceptance -> ALU accepted cycle 0, MEM cycle 1; writes R1 then R2 in cycles 1 and 2, with no gap.
- Fairness: both valid continuously for 6 cycles -> grants strictly alternate ALU, MEM, ALU, MEM, ALU, MEM.
- Scoreboard/hazard:
  - issue_valid with issue_rd=7 in cycle 0, then rs1=7 -> rs_hazard=1 from cycle 1.
  - mem transfer of rd=7 in cycle 4 -> busy[7]=0 in cycle 5, but rs_hazard stays 1 in cycle 5 (RegWrite to R7), and is 0 in cycle 6.
- Set/clear collision: issue_valid with issue_rd=9 in the same cycle as an ALU transfer with alu_rd=9 -> busy[9] remains 1 after the edge.
